// File: rtl/solve_cycle_timer_pkg.sv
// Shared constants for the solve-cycle timer: register map, CTRL/STATUS bit
// positions and FSM state encoding.
package solve_cycle_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_LIMIT  = 2'd2;
  localparam logic [1:0] ADDR_LAST   = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLR   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_SAT     = 3;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                              input logic timeout, input logic sat);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY]    = busy;
    s[STAT_DONE]    = done;
    s[STAT_TIMEOUT] = timeout;
    s[STAT_SAT]     = sat;
    return s;
  endfunction

endpackage

// File: rtl/solve_cycle_timer_prescaler.sv
// Modulo-TICK_DIV phase counter; tick marks the enabled cycle on which the
// phase wraps, so the owner advances once every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  generate
    if (TICK_DIV <= 1) begin : g_bypass
      logic unused_pre;
      assign unused_pre = &{1'b0, clk, reset, clear, en};
      assign tick = 1'b1;
    end else begin : g_div
      localparam int PW = $clog2(TICK_DIV);
      localparam logic [PW-1:0] LAST_PH = PW'(TICK_DIV - 1);
      logic [PW-1:0] phase;

      assign tick = en && (phase == LAST_PH);

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          phase <= '0;
        end else if (en) begin
          phase <= tick ? '0 : phase + PW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/solve_cycle_timer.sv
// Cycle timer around the LBM solver: Avalon-MM control, start/abort handshake,
// saturating solve counter and latched result feeding the solve-time PIO.
module solve_cycle_timer
  import solve_cycle_timer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic             read,
  output logic [31:0]      readdata,
  output logic             solver_start,
  output logic             solver_abort,
  input  logic             solver_done,
  output logic [WIDTH-1:0] solve_time
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("solve_cycle_timer: WIDTH must be in 1..32");
    end
    if (TICK_DIV < 1) begin : g_bad_div
      $error("solve_cycle_timer: TICK_DIV must be >= 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_PEN = COUNT_MAX - WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] last;
  logic             flag_done;
  logic             flag_timeout;
  logic             flag_sat;

  logic ctrl_wr;
  logic start_req;
  logic abort_req;
  logic clr_req;
  logic limit_hit;
  logic start_go;
  logic run_adv;
  logic tick;
  logic unused_bus;

  // Reads are unconditional; upper CTRL bits carry no meaning.
  assign unused_bus = &{1'b0, read, writedata};

  assign ctrl_wr   = write && (address == ADDR_CTRL);
  assign start_req = ctrl_wr && writedata[CTRL_START];
  assign abort_req = ctrl_wr && writedata[CTRL_ABORT];
  assign clr_req   = ctrl_wr && writedata[CTRL_CLR];
  assign limit_hit = (limit != '0) && (count == limit);
  assign start_go  = (state == ST_IDLE) && start_req;
  assign run_adv   = (state == ST_RUN) && !solver_done && !limit_hit && !abort_req;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (start_go),
    .en    (run_adv),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      limit        <= '0;
      last         <= '0;
      flag_done    <= 1'b0;
      flag_timeout <= 1'b0;
      flag_sat     <= 1'b0;
      solver_start <= 1'b0;
      solver_abort <= 1'b0;
    end else begin
      solver_start <= 1'b0;
      solver_abort <= 1'b0;

      if (write && (address == ADDR_LIMIT)) begin
        limit <= writedata[WIDTH-1:0];
      end

      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state        <= ST_RUN;
            solver_start <= 1'b1;
            count        <= '0;
            flag_done    <= 1'b0;
            flag_timeout <= 1'b0;
            flag_sat     <= 1'b0;
          end else if (clr_req) begin
            flag_done    <= 1'b0;
            flag_timeout <= 1'b0;
            flag_sat     <= 1'b0;
          end
        end
        ST_RUN: begin
          // Completion outranks timeout, which outranks a host abort.
          if (solver_done) begin
            last      <= count;
            flag_done <= 1'b1;
            state     <= ST_IDLE;
          end else if (limit_hit) begin
            last         <= count;
            flag_timeout <= 1'b1;
            solver_abort <= 1'b1;
            state        <= ST_IDLE;
          end else if (abort_req) begin
            solver_abort <= 1'b1;
            state        <= ST_IDLE;
          end else if (tick && (count != COUNT_MAX)) begin
            count <= count + WIDTH'(1);
            if (count == COUNT_PEN) begin
              flag_sat <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_STATUS: readdata <= pack_status(state == ST_RUN, flag_done, flag_timeout, flag_sat);
        ADDR_COUNT:  readdata <= 32'(count);
        ADDR_LIMIT:  readdata <= 32'(limit);
        ADDR_LAST:   readdata <= 32'(last);
        default:     readdata <= '0;
      endcase
    end
  end

  assign solve_time = last;

endmodule

// File: doc/solve_cycle_timer.md
Name: solve_cycle_timer

Overview:
Measures how long the LBM solver core takes per solve, and publishes the result as a 32-bit value on `solve_time`. That output drives the input port of the solve-time PIO that the HPS reads, so this block is the producer end of that PIO.
- The HPS controls it through a small Avalon-MM slave: start, abort, timeout limit, status.
- It drives a start/abort handshake to the solver and counts cycles until `solver_done`.

Parameters:
- `WIDTH`, 32: counter, limit and `solve_time` width; must be ≤ 32.
- `TICK_DIV`, 1: clock cycles per count increment; must be ≥ 1.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `address`  in  2  Avalon-MM slave word address
- `write`  in  1  Avalon write strobe
- `writedata`  in  32  Avalon write data
- `read`  in  1  Avalon read strobe
- `readdata`  out  32  registered read data
- `solver_start`  out  1  one-cycle start pulse to solver
- `solver_abort`  out  1  one-cycle abort pulse to solver
- `solver_done`  in  1  solver completion, sampled each cycle
- `solve_time`  out  WIDTH  last latched solve count (to the PIO input port)

Behaviour:
- One clock domain. Reset is synchronous, active-high, named `reset`.
- Reset values: `readdata`, `solve_time`, count, limit, prescaler and all flags are 0; `solver_start` and `solver_abort` are 0; state is IDLE.
- Register map; unused bits read 0:
  - Address 0, write is CTRL: bit0 START, bit1 ABORT, bit2 CLR_FLAGS.
  - Address 0, read is STATUS: bit0 busy, bit1 done, bit2 timeout, bit3 saturated.
  - Address 1, read: live count. Writes ignored.
  - Address 2, read/write: LIMIT (low WIDTH bits). 0 = no limit.
  - Address 3, read: last latched value, equal to `solve_time`. Writes ignored.
- Read latency is fixed at 1:
  - `readdata` is registered every cycle from the addressed register.
  - `read` is not required to gate it.
  - There is no waitrequest.
- Write with `address`=0 in IDLE:
  - START=1: next cycle state=RUN, `solver_start`=1 for exactly that cycle, count=0, prescaler=0. Done, timeout and saturated are cleared.
  - CLR_FLAGS=1: clears the done, timeout and saturated flags.
- RUN, evaluated each cycle in this priority order:
  1. `solver_done`=1: latch count into LAST and `solve_time`; done=1; next state IDLE.
  2. LIMIT≠0 and count==LIMIT: latch count; timeout=1; `solver_abort` pulse next cycle; next state IDLE.
  3. CTRL write with ABORT=1: `solver_abort` pulse next cycle; next state IDLE. No latch; done stays 0.
  4. Otherwise the prescaler advances. On wrap (TICK_DIV−1 → 0) count increments, saturating at all-ones; reaching all-ones sets saturated. Count never wraps.
- Cycle timing (TICK_DIV=1): START write at cycle t gives count 0 at t+1. If `solver_done` is first high at cycle t+1+N, the latched value is N.
- Ignored events:
  - START while in RUN.
  - ABORT while in IDLE.
  - `solver_done` while in IDLE.
- A LIMIT write during RUN takes effect on the next cycle's compare.
- If LIMIT is written below the current count, the run continues until done, saturation or abort; no timeout fires.
- `solve_time` changes only on a latch and holds between runs.
- Reset mid-RUN: return to IDLE, no abort pulse, everything cleared.

Decomposition:
- Shared package:
  - register address constants (CTRL/STATUS=0, COUNT=1, LIMIT=2, LAST=3);
  - CTRL and STATUS bit-index constants;
  - state enum (IDLE, RUN).
- One natural sub-module, `tick_prescaler`: modulo-TICK_DIV counter with sync clear and a tick output. With TICK_DIV=1 it is a constant 1.
- The FSM, counter, register file and read mux stay in the top module.

Test Plan:
1. Reset, then read each address → `readdata`=0 one cycle after each read; `solve_time`=0; no pulses.
2. Write CTRL=0x1; hold `solver_done`=0 for 99 cycles after the start pulse, then raise it → exactly one `solver_start` cycle; `solve_time`=99; STATUS=0x2.
3. LIMIT=50, START, `solver_done` never asserted → `solver_abort` pulses once; `solve_time`=50; STATUS=0x4. A `solver_done` in the same cycle as count==50 gives STATUS=0x2 instead.
4. START, then ABORT write at count 20 → one `solver_abort` pulse; `solve_time` keeps its previous value; STATUS=0x0.
5. `TICK_DIV`=4, START, done at cycle t+1+40 → latched value 10. Second START while busy → no extra `solver_start` pulse and count not cleared.
6. `WIDTH`=8, no limit, done withheld 300 cycles → count holds 0xFF, STATUS=0x9. Assert `reset` mid-run → IDLE, STATUS=0, no abort pulse.
